// File: rtl/srrc_mac_sequencer.sv
// srrc_mac_sequencer
// Time-shared 21-tap symmetric SRRC filter: one pre-adder and one 19x18
// multiplier, stepped over the 11 coefficient groups once per accepted sample.
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   sam_en, x_in       sample strobe and signed 1s17 sample
//   cfg_we/addr/data   coefficient write port (b[0..10], b[10] = centre tap)
//   y, y_valid         registered 1s17 output and its one-cycle strobe
//   busy               high while a sample is being processed (RUN/DONE)
//   overrun            sticky flag: a sample strobe arrived during RUN
//   cfg_err            one-cycle pulse: coefficient write rejected
module srrc_mac_sequencer #(
  parameter int DW    = 18,
  parameter int ACCW  = 40,
  parameter int NCOEF = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sam_en,
  input  logic [DW-1:0] x_in,
  input  logic          cfg_we,
  input  logic [3:0]    cfg_addr,
  input  logic [DW-1:0] cfg_data,
  output logic [DW-1:0] y,
  output logic          y_valid,
  output logic          busy,
  output logic          overrun,
  output logic          cfg_err
);

  localparam int NTAP = 2 * NCOEF - 1;
  localparam int KW   = 4;
  localparam int FRAC = DW - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic signed [DW-1:0]   x_q [NTAP];
  logic signed [DW-1:0]   x_d [NTAP];
  logic signed [DW-1:0]   b_q [NCOEF];
  logic signed [DW-1:0]   b_d [NCOEF];
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [KW-1:0]          k_q, k_d;
  logic [DW-1:0]          y_q, y_d;
  logic                   y_valid_q, y_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   cfg_err_q, cfg_err_d;

  // Datapath: pre-add of the symmetric tap pair, full-precision multiply.
  logic signed [DW-1:0]     xa, xb, bk;
  logic signed [DW:0]       s;
  logic signed [2*DW:0]     prod;
  logic signed [ACCW-1:0]   prod_ext;
  logic signed [ACCW-1:0]   acc_sh;
  logic [ACCW-DW:0]         acc_top;
  logic [DW-1:0]            y_sat;

  always_comb begin
    xa = '0;
    xb = '0;
    bk = '0;
    for (int unsigned i = 0; i < NCOEF; i++) begin
      if (k_q == KW'(i)) begin
        xa = x_q[i];
        xb = x_q[NTAP-1-i];
        bk = b_q[i];
      end
    end
    // Centre tap has no partner.
    if (k_q == KW'(NCOEF - 1)) s = {xa[DW-1], xa};
    else                       s = {xa[DW-1], xa} + {xb[DW-1], xb};
    prod     = (2*DW+1)'(s) * (2*DW+1)'(bk);
    prod_ext = {{(ACCW-2*DW-1){prod[2*DW]}}, prod};
    // Floor shift, then clamp when the bits above the output don't match the sign.
    acc_sh  = acc_q >>> FRAC;
    acc_top = acc_sh[ACCW-1:DW-1];
    if (acc_top == '0 || acc_top == '1) y_sat = acc_sh[DW-1:0];
    else if (acc_sh[ACCW-1])            y_sat = {1'b1, {(DW-1){1'b0}}};
    else                                y_sat = {1'b0, {(DW-1){1'b1}}};
  end

  logic cfg_ok;
  logic start;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    b_d       = b_q;
    acc_d     = acc_q;
    k_d       = k_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    overrun_d = overrun_q;
    cfg_err_d = 1'b0;

    cfg_ok = cfg_we && (state_q == IDLE) && (cfg_addr <= KW'(NCOEF - 1));
    if (cfg_we && !cfg_ok) cfg_err_d = 1'b1;
    for (int unsigned i = 0; i < NCOEF; i++) begin
      if (cfg_ok && cfg_addr == KW'(i)) b_d[i] = cfg_data;
    end

    start = sam_en && (state_q == IDLE || state_q == DONE);

    case (state_q)
      RUN: begin
        acc_d = acc_q + prod_ext;
        k_d   = k_q + 1'b1;
        if (k_q == KW'(NCOEF - 1)) state_d = DONE;
        if (sam_en) overrun_d = 1'b1;
      end
      DONE: begin
        y_d       = y_sat;
        y_valid_d = 1'b1;
        acc_d     = '0;
        state_d   = IDLE;
      end
      default: ;
    endcase

    // A sample accepted in DONE overrides the return to IDLE; acc is cleared either way.
    if (start) begin
      x_d[0] = x_in;
      for (int unsigned i = 1; i < NTAP; i++) x_d[i] = x_q[i-1];
      acc_d   = '0;
      k_d     = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      for (int unsigned i = 0; i < NTAP; i++) x_q[i] <= '0;
      for (int unsigned i = 0; i < NCOEF - 1; i++) b_q[i] <= '0;
      b_q[NCOEF-1] <= {1'b0, {(DW-1){1'b1}}};
      acc_q     <= '0;
      k_q       <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      k_q       <= k_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      overrun_q <= overrun_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign busy    = (state_q != IDLE);
  assign overrun = overrun_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: doc/srrc_mac_sequencer.md
Name: srrc_mac_sequencer

Overview:
Time-shared controller and datapath for the 21-tap symmetric SRRC pulse-shaping filter: one pre-adder and one 18x19 multiplier, run over the 11 coefficient groups once per input sample.
- Sits between the symbol mapper (sample strobe + 1s17 sample) and the DAC/upsampler path.
- Owns a programmable 11-entry coefficient register file, so coefficient sets can be swapped at run time without re-synthesis.

Parameters:
DW, 18, sample, coefficient and output width (fixed 1s17 format; only 18 supported)
ACCW, 40, accumulator width (must be >= 40)
NCOEF, 11, coefficient groups for 21 symmetric taps (fixed)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sam_en  in  1  one-cycle strobe: x_in valid
x_in  in  18  input sample, signed 1s17
cfg_we  in  1  coefficient write strobe
cfg_addr  in  4  coefficient index 0..10 (b[k] weights taps k and 20-k; b[10] is the centre tap)
cfg_data  in  18  coefficient value, signed 1s17
y  out  18  filter output, signed 1s17, registered
y_valid  out  1  one-cycle strobe: y updated
busy  out  1  high in RUN and DONE
overrun  out  1  sticky: sam_en was dropped
cfg_err  out  1  one-cycle pulse: cfg write rejected

Behaviour:
Reset (async) values:
- y=0, y_valid=0, busy=0, overrun=0, cfg_err=0.
- Delay line x[0..20]=0, acc=0, k=0, state=IDLE.
- Coefficients: b[0..9]=0, b[10]=131071, i.e. a pure 10-sample delay.
- Reset mid-operation aborts the computation. No output strobe is produced for the aborted sample.

State machine:
- States are IDLE, RUN, DONE.
- IDLE: on sam_en, shift the delay line (x[0]<=x_in, x[i]<=x[i-1]), set acc<=0 and k<=0, go to RUN.
- RUN, one group per clock: acc <= acc + p(k), k <= k+1. After the edge that accumulates k=10, go to DONE (11 RUN cycles).
  - p(k) = s(k)*b[k], full precision (37 bits, sign-extended into ACCW).
  - s(k) = sext(x[k]) + sext(x[20-k]), 19 bits, 2s17, for k<=9.
  - s(10) = sext(x[10]).
- DONE: y <= sat18(acc >>> 17), y_valid <= 1 for exactly one cycle, then go to IDLE.
  - If sam_en is also asserted in DONE, accept the new sample exactly as in IDLE and go to RUN.
  - The same edge that outputs y clears acc.
- Timing:
  - Latency: y_valid is high 12 clocks after the clock edge that captured sam_en.
  - Minimum sample spacing: 12 clocks.

Arithmetic:
- Output is truncated (floor) in the >>>17 step; no rounding.
- sat18 clamps to [-131072, 131071].

Overrun:
- sam_en in RUN drops the sample: delay line untouched, computation unaffected.
- overrun is set and stays set until reset.

Configuration:
- cfg_we in IDLE with cfg_addr<=10: b[cfg_addr] <= cfg_data on that edge.
- cfg_we in RUN or DONE, or with cfg_addr>10, is rejected: no write occurs and cfg_err pulses for 1 cycle.
- cfg_we and sam_en together in IDLE: the write and the sample start both occur. The write takes effect for this sample, because coefficients are first read in the following RUN cycle.

Test Plan:
- Default coefficients after reset; sam_en every 12 clocks, x_in=65536 on sample 0 then 0 -> y_valid every 12 clocks; y=65535 only on output 10, y=0 otherwise.
- Write b[10]=0 and b[0]=131071 in IDLE; send an impulse of 65536 -> y=65535 on outputs 0 and 20, 0 elsewhere.
- Write all b=131071; 21 samples of 131071 -> final y=131071 (saturated). Repeat with -131072 -> y=-131072.
- cfg_we with cfg_addr=3 while busy=1 -> cfg_err=1 for one cycle, b[3] unchanged (confirm with an impulse). cfg_addr=12 in IDLE -> cfg_err pulse.
- sam_en at RUN cycle 5 (x_in=100000) -> overrun=1 and stays high; that sample does not enter the delay line; the current y is unchanged vs. the reference model; the next y_valid still arrives 12 clocks after the accepted strobe.
- Reset asserted at RUN cycle 6 -> same clock: y=0, busy=0, y_valid=0, b[10]=131071. No y_valid for the aborted sample. The next sam_en behaves as the first sample after reset.
